watch_mode_controller: RTL and testbench
========================================

# watch_mode_controller

Parametrised mode sequencer and display router for the digital watch top level. It replaces the button-clocked 3-state mode register with a fully synchronous controller for 2–8 modes. It routes debounced function buttons as single-cycle pulses to the active mode only, muxes each mode's three display fields onto the shared seven-segment drivers with per-field blink gating, and returns to timekeeping after inactivity. It sits between the SignalDebounce instances and the Timekeeper, Stopwatch, Alarm and DisplayDriver blocks.

## Interface
- NUM_MODES, 3, number of modes (2..8); mode 0 is timekeeping
- FIELD_W, 7, width of each display field
- CLK_HZ, 50_000_000, clock frequency in Hz
- BLINK_HZ, 2, blink rate in Hz (full on/off period)
- TIMEOUT_S, 30, inactivity seconds before auto-return to mode 0
- Clk_50MHz  in  1  system clock; one clock, all logic on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Btn_Mode  in  1  debounced mode button level
- Btn_Func  in  3  debounced Button1..3 levels
- Alarm_Active  in  1  alarm currently sounding
- Src_Sec, Src_Min, Src_Hr  in  NUM_MODES*FIELD_W each  per-mode field sources; mode m at bits [m*FIELD_W +: FIELD_W]
- Src_BlinkMask  in  NUM_MODES*3  per-mode blink request {hr,min,sec}
- Mode  out  3  current mode index
- Mode_OneHot  out  NUM_MODES  one-hot of Mode
- Func_Pulse  out  NUM_MODES*3  routed button pulses; mode m, button j at bit m*3+j
- Alarm_Stop  out  1  one-cycle alarm stop pulse
- Disp_Sec, Disp_Min, Disp_Hr  out  FIELD_W  selected fields
- Disp_Blank  out  3  {hr,min,sec} blank request to display drivers

## Operation
- Reset values: Mode=0, Mode_OneHot=1, Func_Pulse=0, Alarm_Stop=0, Disp_*=0, Disp_Blank=0, blink phase = visible, timeout counter = 0.
- Each button goes through a one-flop sample plus a previous-value flop. A rise is sample=1 and previous=0.
- Mode rise: Mode ← (Mode==NUM_MODES-1) ? 0 : Mode+1.
- Func rise on button j:
  - Func_Pulse[Mode*3+j] pulses, using the Mode value before any same-edge update.
  - All other Func_Pulse bits stay 0.
- Button 3 rise while Alarm_Active=1:
  - Alarm_Stop pulses.
  - The rise is consumed and is not routed to Func_Pulse, in any mode.
- Simultaneous Mode and Func rises: both act. The func pulse goes to the old mode.
- Blink generator:
  - Phase toggles every CLK_HZ/(2*BLINK_HZ) cycles.
  - The counter and phase reset to visible on every mode change.
  - Disp_Blank = mask(Mode) & {3{phase_off}}.
- Display fields are registered from Src_*(Mode).

## Timing
- A level rise sampled at edge t:
  - Func_Pulse/Alarm_Stop are high for exactly the cycle after edge t+1.
  - Mode updates at edge t+1.
  - Disp_* and Disp_Blank reflect the new mode from edge t+2.
- A held button produces one pulse only; the next pulse requires release (≥1 low sample).
- Timeout counter:
  - Width is clog2(TIMEOUT_S*CLK_HZ).
  - Cleared on any button rise and whenever Mode=0; increments otherwise.
  - At count TIMEOUT_S*CLK_HZ-1: Mode ← 0 on the next edge and the counter clears.
  - A button rise on that same edge wins: Mode follows the button rule and no return occurs.
- Reset asserted mid-operation clears all state immediately. Pulses in flight are dropped; no pulse is generated from buttons already high at reset release.

## Configuration
- WATCH_MODE_TIMEOUT_EN defined: auto-return to mode 0 as specified; TIMEOUT_S is used.
- Not defined: no timeout counter is synthesised, Mode changes only on Btn_Mode, and TIMEOUT_S is ignored.

## Test plan
All scenarios use bench parameters CLK_HZ=100, BLINK_HZ=25, TIMEOUT_S=1, NUM_MODES=3, FIELD_W=7.
- Reset, then 4 Btn_Mode presses (high 3 cycles, low 3 cycles) → Mode 0→1→2→0→1; Mode_OneHot 001→010→100→001→010.
- Mode=1, Btn_Func[1] held 10 cycles → Func_Pulse bit 4 high for exactly one cycle; all other bits 0.
- Mode=0, Alarm_Active=1, Btn_Func[2] rise → Alarm_Stop one-cycle pulse; Func_Pulse bit 2 stays 0.
- Mode=2, Src_Sec(2)=7'd45, Src_BlinkMask(2)=3'b001:
  - Disp_Sec=45.
  - Disp_Blank toggles 000/001 every 2 cycles, starting visible after the mode change.
- Btn_Mode and Btn_Func[0] rise together in Mode=0 → Func_Pulse bit 0 pulses; Mode=1.
- Mode=1, no buttons for 100 cycles → Mode=0 (with WATCH_MODE_TIMEOUT_EN); Mode stays 1 without the macro.

Source files
------------

// File: rtl/watch_mode_controller.sv
// Mode sequencer, button router and display mux for the watch top level.
// Optional inactivity auto-return to mode 0 under WATCH_MODE_TIMEOUT_EN.
module watch_mode_controller #(
    parameter int NUM_MODES = 3,
    parameter int FIELD_W   = 7,
    parameter int CLK_HZ    = 50_000_000,
    parameter int BLINK_HZ  = 2,
    parameter int TIMEOUT_S = 30
) (
    input  logic                         Clk_50MHz,
    input  logic                         Reset_n,
    input  logic                         Btn_Mode,
    input  logic [2:0]                   Btn_Func,
    input  logic                         Alarm_Active,
    input  logic [NUM_MODES*FIELD_W-1:0] Src_Sec,
    input  logic [NUM_MODES*FIELD_W-1:0] Src_Min,
    input  logic [NUM_MODES*FIELD_W-1:0] Src_Hr,
    input  logic [NUM_MODES*3-1:0]       Src_BlinkMask,
    output logic [2:0]                   Mode,
    output logic [NUM_MODES-1:0]         Mode_OneHot,
    output logic [NUM_MODES*3-1:0]       Func_Pulse,
    output logic                         Alarm_Stop,
    output logic [FIELD_W-1:0]           Disp_Sec,
    output logic [FIELD_W-1:0]           Disp_Min,
    output logic [FIELD_W-1:0]           Disp_Hr,
    output logic [2:0]                   Disp_Blank
);

    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [3:0]             btn_s_q, btn_s_d;
    logic [3:0]             btn_p_q, btn_p_d;
    logic [3:0]             rise;
    logic [2:0]             mode_q, mode_d;
    logic [NUM_MODES*3-1:0] pulse_q, pulse_d;
    logic                   stop_q, stop_d;
    logic [FIELD_W-1:0]     sec_q, sec_d;
    logic [FIELD_W-1:0]     min_q, min_d;
    logic [FIELD_W-1:0]     hr_q, hr_d;
    logic [2:0]             blank_q, blank_d;
    logic [BW-1:0]          bcnt_q, bcnt_d;
    logic                   phase_q, phase_d;
    logic                   to_hit;

    assign rise = btn_s_q & ~btn_p_q;

`ifdef WATCH_MODE_TIMEOUT_EN
    localparam longint TO = longint'(TIMEOUT_S) * longint'(CLK_HZ);
    localparam int     TW = (TO > 1) ? $clog2(TO) : 1;

    logic [TW-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_hit   = (mode_q != 3'd0) && (to_cnt_q == TW'(TO - 1)) && !(|rise);
        to_cnt_d = to_cnt_q + 1'b1;
        if ((|rise) || (mode_q == 3'd0) || to_hit) begin
            to_cnt_d = '0;
        end
    end

    always_ff @(posedge Clk_50MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        // Flops reset high so buttons held through reset never look like a rise
        btn_s_d = {Btn_Func, Btn_Mode};
        btn_p_d = btn_s_q;

        mode_d = mode_q;
        if (rise[0]) begin
            mode_d = (mode_q == 3'(NUM_MODES - 1)) ? 3'd0 : mode_q + 3'd1;
        end else if (to_hit) begin
            mode_d = 3'd0;
        end

        stop_d  = rise[3] & Alarm_Active;
        pulse_d = '0;
        for (int m = 0; m < NUM_MODES; m++) begin
            for (int j = 0; j < 3; j++) begin
                if (mode_q == 3'(m) && rise[j+1] && !(j == 2 && Alarm_Active)) begin
                    pulse_d[m*3+j] = 1'b1;
                end
            end
        end

        bcnt_d  = bcnt_q + 1'b1;
        phase_d = phase_q;
        if (mode_d != mode_q) begin
            bcnt_d  = '0;
            phase_d = 1'b0;
        end else if (bcnt_q == BW'(HALF - 1)) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end

        sec_d   = '0;
        min_d   = '0;
        hr_d    = '0;
        blank_d = '0;
        for (int m = 0; m < NUM_MODES; m++) begin
            if (mode_q == 3'(m)) begin
                sec_d   = Src_Sec[m*FIELD_W +: FIELD_W];
                min_d   = Src_Min[m*FIELD_W +: FIELD_W];
                hr_d    = Src_Hr[m*FIELD_W +: FIELD_W];
                blank_d = Src_BlinkMask[m*3 +: 3] & {3{phase_q}};
            end
        end
    end

    always_ff @(posedge Clk_50MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            btn_s_q <= '1;
            btn_p_q <= '1;
            mode_q  <= '0;
            pulse_q <= '0;
            stop_q  <= 1'b0;
            sec_q   <= '0;
            min_q   <= '0;
            hr_q    <= '0;
            blank_q <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            btn_s_q <= btn_s_d;
            btn_p_q <= btn_p_d;
            mode_q  <= mode_d;
            pulse_q <= pulse_d;
            stop_q  <= stop_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hr_q    <= hr_d;
            blank_q <= blank_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end

    assign Mode        = mode_q;
    assign Mode_OneHot = NUM_MODES'(1) << mode_q;
    assign Func_Pulse  = pulse_q;
    assign Alarm_Stop  = stop_q;
    assign Disp_Sec    = sec_q;
    assign Disp_Min    = min_q;
    assign Disp_Hr     = hr_q;
    assign Disp_Blank  = blank_q;

endmodule

// File: tb/tb_watch_mode_controller.sv
// Scoreboard bench for watch_mode_controller with scaled-down timing.
// Covers mode stepping, routing, alarm stop, blink, display and timeout.
module tb_watch_mode_controller;

    localparam int NM = 3;
    localparam int FW = 7;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             btn_mode = 1'b0;
    logic [2:0]       btn_func = 3'b000;
    logic             alarm = 1'b0;
    logic [NM*FW-1:0] src_sec;
    logic [NM*FW-1:0] src_min;
    logic [NM*FW-1:0] src_hr;
    logic [NM*3-1:0]  src_mask;
    logic [2:0]       mode;
    logic [NM-1:0]    mode_oh;
    logic [NM*3-1:0]  fpulse;
    logic             astop;
    logic [FW-1:0]    d_sec;
    logic [FW-1:0]    d_min;
    logic [FW-1:0]    d_hr;
    logic [2:0]       d_blank;

    int          checks = 0;
    int          errors = 0;
    int unsigned exp_q[$];
    int unsigned sec_tab[3] = '{11, 21, 45};

    watch_mode_controller #(
        .NUM_MODES(NM),
        .FIELD_W  (FW),
        .CLK_HZ   (100),
        .BLINK_HZ (25),
        .TIMEOUT_S(1)
    ) dut (
        .Clk_50MHz    (clk),
        .Reset_n      (rst_n),
        .Btn_Mode     (btn_mode),
        .Btn_Func     (btn_func),
        .Alarm_Active (alarm),
        .Src_Sec      (src_sec),
        .Src_Min      (src_min),
        .Src_Hr       (src_hr),
        .Src_BlinkMask(src_mask),
        .Mode         (mode),
        .Mode_OneHot  (mode_oh),
        .Func_Pulse   (fpulse),
        .Alarm_Stop   (astop),
        .Disp_Sec     (d_sec),
        .Disp_Min     (d_min),
        .Disp_Hr      (d_hr),
        .Disp_Blank   (d_blank)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got);
        int unsigned exp;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        repeat (3) tick();
        btn_mode = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        int exp_mode;
        int cnt;
        int bad;
        src_sec  = {7'd45, 7'd21, 7'd11};
        src_min  = {7'd32, 7'd22, 7'd12};
        src_hr   = {7'd3, 7'd2, 7'd1};
        src_mask = {3'b001, 3'b000, 3'b000};

        repeat (3) tick();
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(0);
        exp_q.push_back(0);
        exp_q.push_back(0);
        exp_q.push_back(0);
        check("rst_mode", mode);
        check("rst_onehot", mode_oh);
        check("rst_fpulse", fpulse);
        check("rst_astop", astop);
        check("rst_dsec", d_sec);
        check("rst_blank", d_blank);

        rst_n = 1'b1;
        tick();
        exp_q.push_back(11);
        check("disp_m0", d_sec);

        exp_mode = 0;
        for (int i = 0; i < 4; i++) begin
            exp_mode = (exp_mode + 1) % NM;
            exp_q.push_back(exp_mode);
            exp_q.push_back(1 << exp_mode);
            exp_q.push_back(sec_tab[exp_mode]);
            exp_q.push_back(0);
            press_mode();
            check("mode_step", mode);
            check("onehot_step", mode_oh);
            check("disp_step", d_sec);
            check("fp_quiet", fpulse);
        end

        exp_q.push_back(1);
        exp_q.push_back(0);
        btn_func = 3'b010;
        cnt = 0;
        bad = 0;
        repeat (10) begin
            tick();
            if (fpulse == 9'h010) cnt++;
            else if (fpulse != 0) bad++;
        end
        btn_func = 3'b000;
        repeat (2) tick();
        check("fp_m1b1_cnt", cnt);
        check("fp_m1b1_other", bad);

        exp_q.push_back(2);
        for (int k = 1; k <= 8; k++) begin
            exp_q.push_back((((k - 1) / 2) % 2) != 0 ? 1 : 0);
        end
        btn_mode = 1'b1;
        repeat (2) tick();
        check("mode_to2", mode);
        for (int k = 1; k <= 8; k++) begin
            if (k == 2) btn_mode = 1'b0;
            tick();
            check("blink", d_blank);
        end
        exp_q.push_back(45);
        exp_q.push_back(32);
        exp_q.push_back(3);
        check("disp_sec2", d_sec);
        check("disp_min2", d_min);
        check("disp_hr2", d_hr);

        exp_q.push_back(0);
        exp_q.push_back(0);
        press_mode();
        check("mode_wrap", mode);
        check("blank_m0", d_blank);

        exp_q.push_back(1);
        exp_q.push_back(0);
        alarm = 1'b1;
        btn_func = 3'b100;
        cnt = 0;
        bad = 0;
        repeat (6) begin
            tick();
            if (astop) cnt++;
            if (fpulse != 0) bad++;
        end
        btn_func = 3'b000;
        tick();
        alarm = 1'b0;
        check("astop_cnt", cnt);
        check("astop_consumed", bad);

        exp_q.push_back(1);
        exp_q.push_back(0);
        exp_q.push_back(1);
        btn_mode = 1'b1;
        btn_func = 3'b001;
        cnt = 0;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            if (k == 3) begin
                btn_mode = 1'b0;
                btn_func = 3'b000;
            end
            tick();
            if (fpulse == 9'h001) cnt++;
            else if (fpulse != 0) bad++;
        end
        check("simul_fp_cnt", cnt);
        check("simul_fp_other", bad);
        check("simul_mode", mode);

        exp_q.push_back(1);
        repeat (90) tick();
        check("to_before", mode);
`ifdef WATCH_MODE_TIMEOUT_EN
        exp_q.push_back(0);
`else
        exp_q.push_back(1);
`endif
        repeat (10) tick();
        check("to_after", mode);

        exp_q.push_back(0);
        exp_q.push_back(0);
        exp_q.push_back(0);
        btn_mode = 1'b1;
        btn_func = 3'b001;
        rst_n = 1'b0;
        tick();
        check("midrst_mode", mode);
        rst_n = 1'b1;
        cnt = 0;
        repeat (5) begin
            tick();
            if (fpulse != 0) cnt++;
        end
        check("held_rel_fp", cnt);
        check("held_rel_mode", mode);
        btn_mode = 1'b0;
        btn_func = 3'b000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
